// File: rtl/i2c_target_regfile.sv
// I2C target exposing a small byte-wide register file: device address, pointer byte, then
// auto-incrementing data bytes. SCL/SDA are oversampled on clk; SDA is open-drain (0 or Z).
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'b0101010,
    parameter int         REG_AW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              wr_strobe,
    output logic [REG_AW-1:0] wr_reg,
    output logic [7:0]        wr_data,
    output logic              busy,
    input  logic [REG_AW-1:0] host_idx,
    output logic [7:0]        host_data
);
    localparam int NREG = 1 << REG_AW;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    // Synchronizers reset to the idle-bus level so releasing reset never fakes an edge.
    logic scl_meta_reg, scl_sync_reg, scl_prev_reg;
    logic sda_meta_reg, sda_sync_reg, sda_prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_meta_reg <= 1'b1;
            scl_sync_reg <= 1'b1;
            scl_prev_reg <= 1'b1;
            sda_meta_reg <= 1'b1;
            sda_sync_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_meta_reg <= scl;
            scl_sync_reg <= scl_meta_reg;
            scl_prev_reg <= scl_sync_reg;
            sda_meta_reg <= sda;
            sda_sync_reg <= sda_meta_reg;
            sda_prev_reg <= sda_sync_reg;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_sync_reg & ~scl_prev_reg;
    assign scl_fall  = ~scl_sync_reg & scl_prev_reg;
    assign start_det = scl_sync_reg & ~sda_sync_reg & sda_prev_reg;
    assign stop_det  = scl_sync_reg & sda_sync_reg & ~sda_prev_reg;

    state_t            state_reg, state_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        rx_reg, rx_next;
    logic [7:0]        tx_reg, tx_next;
    logic [REG_AW-1:0] ptr_reg, ptr_next;
    logic              oe_reg, oe_next;
    logic              busy_reg, busy_next;
    logic              rw_reg, rw_next;
    logic              rd_ack_reg, rd_ack_next;
    logic              strobe_reg, strobe_next;
    logic [REG_AW-1:0] wr_reg_reg, wr_reg_next;
    logic [7:0]        wr_data_reg, wr_data_next;
    logic              reg_we;
    logic [NREG-1:0]   reg_sel;
    logic [7:0]        regs [NREG];
    logic [7:0]        rd_byte;

    assign rd_byte = regs[ptr_reg];

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        rx_next      = rx_reg;
        tx_next      = tx_reg;
        ptr_next     = ptr_reg;
        oe_next      = oe_reg;
        busy_next    = busy_reg;
        rw_next      = rw_reg;
        rd_ack_next  = rd_ack_reg;
        strobe_next  = 1'b0;
        wr_reg_next  = wr_reg_reg;
        wr_data_next = wr_data_reg;
        reg_we       = 1'b0;
        if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = 4'd0;
            rx_next      = 8'd0;
            oe_next      = 1'b0;
            rd_ack_next  = 1'b0;
        end else if (stop_det) begin
            state_next = IDLE;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bit_cnt_reg != 4'd8) begin
                        rx_next      = {rx_reg[6:0], sda_sync_reg};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        bit_cnt_next = 4'd0;
                        oe_next      = 1'b1;
                        if (state_reg == ADDR) begin
                            if (rx_reg[7:1] == DEV_ADDR) begin
                                state_next = ADDR_ACK;
                                busy_next  = 1'b1;
                                rw_next    = rx_reg[0];
                            end else begin
                                state_next = IDLE;
                                busy_next  = 1'b0;
                                oe_next    = 1'b0;
                            end
                        end else if (state_reg == PTR) begin
                            ptr_next   = rx_reg[REG_AW-1:0];
                            state_next = PTR_ACK;
                        end else begin
                            reg_we       = 1'b1;
                            strobe_next  = 1'b1;
                            wr_reg_next  = ptr_reg;
                            wr_data_next = rx_reg;
                            ptr_next     = ptr_reg + 1'b1;
                            state_next   = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_reg) begin
                            state_next   = RDATA;
                            tx_next      = rd_byte;
                            oe_next      = ~rd_byte[7];
                            bit_cnt_next = 4'd1;
                        end else begin
                            state_next   = PTR;
                            oe_next      = 1'b0;
                            bit_cnt_next = 4'd0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_next   = WDATA;
                        oe_next      = 1'b0;
                        bit_cnt_next = 4'd0;
                    end
                end
                RDATA: begin
                    // bit_cnt counts bits already placed on the bus
                    if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            oe_next     = 1'b0;
                            state_next  = RDATA_ACK;
                            rd_ack_next = 1'b0;
                        end else begin
                            oe_next      = ~tx_reg[6];
                            tx_next      = {tx_reg[6:0], 1'b0};
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_sync_reg) begin
                            ptr_next    = ptr_reg + 1'b1;
                            rd_ack_next = 1'b1;
                        end else begin
                            state_next = IDLE;
                            busy_next  = 1'b0;
                        end
                    end else if (scl_fall && rd_ack_reg) begin
                        state_next   = RDATA;
                        tx_next      = rd_byte;
                        oe_next      = ~rd_byte[7];
                        bit_cnt_next = 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 4'd0;
            rx_reg      <= 8'd0;
            tx_reg      <= 8'd0;
            ptr_reg     <= '0;
            oe_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            rw_reg      <= 1'b0;
            rd_ack_reg  <= 1'b0;
            strobe_reg  <= 1'b0;
            wr_reg_reg  <= '0;
            wr_data_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            rx_reg      <= rx_next;
            tx_reg      <= tx_next;
            ptr_reg     <= ptr_next;
            oe_reg      <= oe_next;
            busy_reg    <= busy_next;
            rw_reg      <= rw_next;
            rd_ack_reg  <= rd_ack_next;
            strobe_reg  <= strobe_next;
            wr_reg_reg  <= wr_reg_next;
            wr_data_reg <= wr_data_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sel
            assign reg_sel[gi] = reg_we && (ptr_reg == REG_AW'(gi));
        end
    endgenerate

    // Flop-based file: it needs a reset and an asynchronous host read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (reg_sel[i]) regs[i] <= rx_reg;
            end
        end
    end

    assign sda       = oe_reg ? 1'b0 : 1'bz;
    assign wr_strobe = strobe_reg;
    assign wr_reg    = wr_reg_reg;
    assign wr_data   = wr_data_reg;
    assign busy      = busy_reg;
    assign host_data = regs[host_idx];
endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged master drives the bus, write strobes
// and read bytes are scoreboarded against queues filled when the stimulus is issued.
module tb_i2c_target_regfile;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [1:0] host_idx = 2'd0;
    logic       wr_strobe, busy;
    logic [1:0] wr_reg;
    logic [7:0] wr_data, host_data;
    wire        sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_target_regfile #(.DEV_ADDR(7'b0101010), .REG_AW(2)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .wr_strobe(wr_strobe), .wr_reg(wr_reg), .wr_data(wr_data),
        .busy(busy), .host_idx(host_idx), .host_data(host_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] r;
        logic [7:0] d;
    } wr_t;

    int         errors = 0;
    int         checks = 0;
    wr_t        exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    bit         target_drove = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe scoreboard and a watch for the target pulling SDA low.
    always @(negedge clk) begin
        if (rst && !m_low && sda === 1'b0) target_drove = 1'b1;
        if (wr_strobe === 1'b1) begin
            $display("strobe reg=%0d data=0x%02h", wr_reg, wr_data);
            check("strobe_expected", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) begin
                wr_t e;
                e = exp_wr_q.pop_front();
                check("strobe_reg", 32'(wr_reg), 32'(e.r));
                check("strobe_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        wait_clk(4); m_low = ~b;
        wait_clk(4); scl = 1'b1;
        wait_clk(4); s = sda;
        wait_clk(4); scl = 1'b0;
    endtask

    task automatic start_cond();
        if (scl === 1'b0) begin
            wait_clk(4); m_low = 1'b0;
            wait_clk(4); scl = 1'b1;
        end
        wait_clk(4); m_low = 1'b1;
        wait_clk(4); scl = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(4); m_low = 1'b1;
        wait_clk(4); scl = 1'b1;
        wait_clk(4); m_low = 1'b0;
        wait_clk(8);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
        $display("write byte 0x%02h ack=%0b", b, ack);
    endtask

    task automatic read_byte(input logic master_ack);
        logic [7:0] b;
        logic       s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(~master_ack, s);
        $display("read byte 0x%02h master_ack=%0b", b, master_ack);
        check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
        if (exp_rd_q.size() != 0) check("rd_data", 32'(b), 32'(exp_rd_q.pop_front()));
    endtask

    task automatic host_check(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        host_idx = idx;
        #1;
        check(tag, 32'(host_data), 32'(exp));
    endtask

    initial begin
        logic ack;
        // Reset state
        wait_clk(3);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_reg", 32'(wr_reg), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 4; i++) host_check("rst_regs", 2'(i), 8'h00);

        // Write burst: ptr 1, data AA, 55
        start_cond();
        write_byte(8'h54, ack); check("wb_ack_addr", 32'(ack), 32'd0);
        check("wb_busy", 32'(busy), 32'd1);
        write_byte(8'h01, ack); check("wb_ack_ptr", 32'(ack), 32'd0);
        exp_wr_q.push_back('{r: 2'd1, d: 8'hAA});
        write_byte(8'hAA, ack); check("wb_ack_d0", 32'(ack), 32'd0);
        exp_wr_q.push_back('{r: 2'd2, d: 8'h55});
        write_byte(8'h55, ack); check("wb_ack_d1", 32'(ack), 32'd0);
        stop_cond();
        check("wb_busy_stop", 32'(busy), 32'd0);
        check("wb_strobes_done", 32'(exp_wr_q.size()), 32'd0);
        host_check("wb_reg1", 2'd1, 8'hAA);
        host_check("wb_reg2", 2'd2, 8'h55);

        // Read with repeated START from ptr 1
        start_cond();
        write_byte(8'h54, ack); check("rd_ack_addr", 32'(ack), 32'd0);
        write_byte(8'h01, ack); check("rd_ack_ptr", 32'(ack), 32'd0);
        start_cond();
        write_byte(8'h55, ack); check("rd_ack_addr_r", 32'(ack), 32'd0);
        exp_rd_q.push_back(8'hAA);
        read_byte(1'b1);
        exp_rd_q.push_back(8'h55);
        read_byte(1'b0);
        wait_clk(6);
        check("rd_sda_released", 32'(sda), 32'd1);
        check("rd_busy_nack", 32'(busy), 32'd0);
        stop_cond();

        // Wrong address
        target_drove = 1'b0;
        start_cond();
        write_byte(8'h56, ack); check("wa_nack_addr", 32'(ack), 32'd1);
        check("wa_busy", 32'(busy), 32'd0);
        write_byte(8'h12, ack); check("wa_nack_data", 32'(ack), 32'd1);
        stop_cond();
        check("wa_sda_never_low", 32'(target_drove), 32'd0);
        check("wa_busy_end", 32'(busy), 32'd0);

        // Pointer wrap
        start_cond();
        write_byte(8'h54, ack); check("pw_ack_addr", 32'(ack), 32'd0);
        write_byte(8'h03, ack); check("pw_ack_ptr", 32'(ack), 32'd0);
        exp_wr_q.push_back('{r: 2'd3, d: 8'h11});
        write_byte(8'h11, ack); check("pw_ack_d0", 32'(ack), 32'd0);
        exp_wr_q.push_back('{r: 2'd0, d: 8'h22});
        write_byte(8'h22, ack); check("pw_ack_d1", 32'(ack), 32'd0);
        stop_cond();
        check("pw_strobes_done", 32'(exp_wr_q.size()), 32'd0);
        host_check("pw_reg3", 2'd3, 8'h11);
        host_check("pw_reg0", 2'd0, 8'h22);

        // Aborted byte: four bits of F0 then STOP
        start_cond();
        write_byte(8'h54, ack); check("ab_ack_addr", 32'(ack), 32'd0);
        write_byte(8'h02, ack); check("ab_ack_ptr", 32'(ack), 32'd0);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, ack);
        stop_cond();
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_sda", 32'(sda), 32'd1);
        host_check("ab_reg2", 2'd2, 8'h55);

        // Reset while the target drives a 0 data bit (regs[2]=0x55, MSB 0)
        start_cond();
        write_byte(8'h55, ack); check("rr_ack_addr", 32'(ack), 32'd0);
        wait_clk(6);
        check("rr_driving_low", 32'(sda), 32'd0);
        rst = 1'b0;
        #1;
        check("rr_sda_released", 32'(sda), 32'd1);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_wr_reg", 32'(wr_reg), 32'd0);
        check("rr_wr_data", 32'(wr_data), 32'd0);
        check("rr_strobe", 32'(wr_strobe), 32'd0);
        for (int i = 0; i < 4; i++) host_check("rr_regs", 2'(i), 8'h00);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(2);
        start_cond();
        write_byte(8'h54, ack); check("rr_post_ack_addr", 32'(ack), 32'd0);
        write_byte(8'h00, ack); check("rr_post_ack_ptr", 32'(ack), 32'd0);
        exp_wr_q.push_back('{r: 2'd0, d: 8'h5A});
        write_byte(8'h5A, ack); check("rr_post_ack_data", 32'(ack), 32'd0);
        stop_cond();
        check("rr_strobes_done", 32'(exp_wr_q.size()), 32'd0);
        host_check("rr_post_reg0", 2'd0, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
